// File: rtl/sys_rst_seq_if.sv
// sys_rst_seq_if: request/ack inputs and sequenced reset outputs of the reset sequencer
interface sys_rst_seq_if #(
  parameter int N_STAGE = 4
);
  localparam int SW = N_STAGE > 1 ? $clog2(N_STAGE) : 1;
  logic sw_rst_req;
  logic [N_STAGE-1:0] ack;
  logic [N_STAGE-1:0] rst_out;
  logic busy;
  logic done;
  logic fault;
  logic [SW-1:0] fault_stage;
  modport master(output sw_rst_req, ack, input rst_out, busy, done, fault, fault_stage);
  modport slave(input sw_rst_req, ack, output rst_out, busy, done, fault, fault_stage);
endinterface

// File: rtl/sys_rst_seq.sv
// sys_rst_seq: synchronizes reset release then releases downstream domains in order, gated on acks
module sys_rst_seq #(
  parameter int N_STAGE  = 4,
  parameter int SYNC_LEN = 2,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 8,
  parameter int ACK_TO   = 1024
) (
  input logic clk,
  input logic rst,
  sys_rst_seq_if.slave bus
);
  localparam int SW = N_STAGE > 1 ? $clog2(N_STAGE) : 1;
  localparam int LHG = HOLD_CYC > GAP_CYC ? HOLD_CYC : GAP_CYC;
  localparam int LIM = LHG > ACK_TO ? LHG : ACK_TO;
  localparam int CW = $clog2(LIM + 1) + 1;
  localparam logic [SW-1:0] LAST = SW'(N_STAGE - 1);
  localparam logic [CW-1:0] C_HOLD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] C_GAP = CW'(GAP_CYC);
  localparam logic [CW-1:0] C_TO = CW'(ACK_TO);
  localparam logic [CW-1:0] C_MAX = '1;
  typedef enum logic [2:0] {SYNC, HOLD, WAIT, GAP, DONE, FAULT} state_t;
  state_t state;
  logic [SYNC_LEN-2:0] sync_q;
  logic sw_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [SW-1:0] stg;
  assign cnt_inc = cnt == C_MAX ? cnt : cnt + 1'b1;
  // the state register itself acts as the final synchronizer stage
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '1;
      sw_q <= 1'b0;
      state <= SYNC;
      cnt <= '0;
      stg <= '0;
      bus.rst_out <= '1;
      bus.busy <= 1'b1;
      bus.done <= 1'b0;
      bus.fault <= 1'b0;
      bus.fault_stage <= '0;
    end else begin
      sync_q <= sync_q << 1;
      sw_q <= bus.sw_rst_req && state != SYNC;
      if (sw_q) begin
        state <= HOLD;
        cnt <= '0;
        stg <= '0;
        bus.rst_out <= '1;
        bus.busy <= 1'b1;
        bus.done <= 1'b0;
        bus.fault <= 1'b0;
        bus.fault_stage <= '0;
      end else
        case (state)
          SYNC: if (!sync_q[SYNC_LEN-2]) state <= HOLD;
          HOLD:
            if (cnt == C_HOLD) begin
              bus.rst_out[0] <= 1'b0;
              state <= WAIT;
              cnt <= '0;
            end else cnt <= cnt_inc;
          WAIT:
            if (ACK_TO != 0 && cnt == C_TO) begin
              state <= FAULT;
              bus.rst_out <= '1;
              bus.busy <= 1'b0;
              bus.fault <= 1'b1;
              bus.fault_stage <= stg;
            end else if (bus.ack[stg]) begin
              state <= stg == LAST ? DONE : GAP;
              cnt <= '0;
            end else cnt <= cnt_inc;
          GAP:
            if (cnt == C_GAP) begin
              bus.rst_out[stg+1'b1] <= 1'b0;
              stg <= stg + 1'b1;
              state <= WAIT;
              cnt <= '0;
            end else cnt <= cnt_inc;
          DONE: begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_sys_rst_seq.sv
// tb_sys_rst_seq: timeline model of the release schedule checked every cycle, plus directed literals
module tb_sys_rst_seq;
  localparam int N = 3, SL = 2, HC = 4, GC = 2, TO = 10, INF = 1 << 30;
  logic clk = 1'b0;
  logic rst;
  sys_rst_seq_if #(.N_STAGE(N)) bus ();
  sys_rst_seq #(.N_STAGE(N), .SYNC_LEN(SL), .HOLD_CYC(HC), .GAP_CYC(GC), .ACK_TO(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  int total = 0, passed = 0;
  int n, hold_at, done_at, fault_at, fault_k, cur, pend_at, pend_k, sw_at;
  int rel[N];
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", nm, n, act, exp);
  endtask
  task automatic model_clear();
    done_at = INF;
    fault_at = INF;
    fault_k = 0;
    cur = -1;
    pend_at = INF;
    pend_k = 0;
    sw_at = INF;
    for (int j = 0; j < N; j++) rel[j] = INF;
  endtask
  task automatic model_reset();
    n = 0;
    hold_at = SL;
    model_clear();
  endtask
  // edge n: schedule releases from the hold anchor and observed ack samples
  task automatic model_step();
    n++;
    if (n == sw_at) begin
      model_clear();
      hold_at = n;
    end else if (n == hold_at + HC) begin
      rel[0] = n;
      cur = 0;
    end else if (n == pend_at) begin
      rel[pend_k] = n;
      cur = pend_k;
      pend_at = INF;
    end else if (cur >= 0 && n > rel[cur]) begin
      if (TO != 0 && n == rel[cur] + TO + 1) begin
        fault_at = n;
        fault_k = cur;
        cur = -1;
      end else if (bus.ack[cur]) begin
        if (cur == N - 1) done_at = n + 1;
        else begin
          pend_at = n + GC + 1;
          pend_k = cur + 1;
        end
        cur = -1;
      end
    end
    if (bus.sw_rst_req && n > SL) sw_at = n + 1;
  endtask
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end
  task automatic compare();
    logic [N-1:0] m;
    bit f;
    f = fault_at <= n;
    for (int j = 0; j < N; j++) m[j] = f || rel[j] > n;
    chk("cyc_rst_out", int'(bus.rst_out), int'(m));
    chk("cyc_busy", int'(bus.busy), int'(!f && done_at > n));
    chk("cyc_done", int'(bus.done), int'(done_at <= n));
    chk("cyc_fault", int'(bus.fault), int'(f));
    chk("cyc_fault_stage", int'(bus.fault_stage), f ? fault_k : 0);
  endtask
  initial forever begin
    @(negedge clk);
    compare();
  end
  task automatic run_to(int k);
    int b = 0;
    while (n < k && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("reach_edge", n, k);
  endtask
  task automatic lit(string nm, int k, logic [N-1:0] ro, bit b, bit d, bit f, int fs);
    run_to(k);
    chk({nm, "_rst_out"}, int'(bus.rst_out), int'(ro));
    chk({nm, "_busy"}, int'(bus.busy), int'(b));
    chk({nm, "_done"}, int'(bus.done), int'(d));
    chk({nm, "_fault"}, int'(bus.fault), int'(f));
    chk({nm, "_fault_stage"}, int'(bus.fault_stage), fs);
  endtask
  task automatic por(logic [N-1:0] a, int cyc);
    rst = 1'b1;
    bus.ack = a;
    bus.sw_rst_req = 1'b0;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b0;
    bus.ack = '0;
    bus.sw_rst_req = 1'b0;
    #1 rst = 1'b1;
    // power-on, all acks high
    por(3'b111, 5);
    lit("po_e5", 5, 3'b111, 1, 0, 0, 0);
    lit("po_e6", 6, 3'b110, 1, 0, 0, 0);
    lit("po_e9", 9, 3'b110, 1, 0, 0, 0);
    lit("po_e10", 10, 3'b100, 1, 0, 0, 0);
    lit("po_e14", 14, 3'b000, 1, 0, 0, 0);
    lit("po_e15", 15, 3'b000, 1, 0, 0, 0);
    lit("po_e16", 16, 3'b000, 0, 1, 0, 0);
    bus.ack = 3'b000;
    lit("done_hold", 19, 3'b000, 0, 1, 0, 0);
    bus.sw_rst_req = 1'b1;
    run_to(20);
    bus.sw_rst_req = 1'b0;
    lit("sw_e20", 20, 3'b000, 0, 1, 0, 0);
    lit("sw_e21", 21, 3'b111, 1, 0, 0, 0);
    bus.ack = 3'b111;
    lit("sw_e24", 24, 3'b111, 1, 0, 0, 0);
    lit("sw_e25", 25, 3'b110, 1, 0, 0, 0);
    lit("sw_e34", 34, 3'b000, 1, 0, 0, 0);
    lit("sw_e35", 35, 3'b000, 0, 1, 0, 0);
    // stage 1 never acks
    por(3'b101, 3);
    lit("to_e10", 10, 3'b100, 1, 0, 0, 0);
    lit("to_e20", 20, 3'b100, 1, 0, 0, 0);
    lit("to_e21", 21, 3'b111, 0, 0, 1, 1);
    lit("to_e71", 71, 3'b111, 0, 0, 1, 1);
    bus.sw_rst_req = 1'b1;
    bus.ack = 3'b111;
    run_to(72);
    bus.sw_rst_req = 1'b0;
    lit("fsw_e73", 73, 3'b111, 1, 0, 0, 0);
    lit("fsw_e77", 77, 3'b110, 1, 0, 0, 0);
    // ack[0] on the last allowed sample; sw_rst_req during SYNC ignored
    por(3'b110, 3);
    bus.sw_rst_req = 1'b1;
    run_to(2);
    bus.sw_rst_req = 1'b0;
    lit("late_e6", 6, 3'b110, 1, 0, 0, 0);
    run_to(15);
    bus.ack = 3'b111;
    lit("late_e16", 16, 3'b110, 1, 0, 0, 0);
    lit("late_e18", 18, 3'b110, 1, 0, 0, 0);
    lit("late_e19", 19, 3'b100, 1, 0, 0, 0);
    // ack[0] one sample too late
    por(3'b110, 3);
    run_to(16);
    bus.ack = 3'b111;
    lit("tl_e16", 16, 3'b110, 1, 0, 0, 0);
    lit("tl_e17", 17, 3'b111, 0, 0, 1, 0);
    // sw_rst_req on the same edge as the last-stage ack
    por(3'b011, 3);
    lit("sa_e14", 14, 3'b000, 1, 0, 0, 0);
    run_to(16);
    bus.sw_rst_req = 1'b1;
    bus.ack = 3'b111;
    run_to(17);
    bus.sw_rst_req = 1'b0;
    bus.ack = 3'b011;
    lit("sa_e17", 17, 3'b000, 1, 0, 0, 0);
    lit("sa_e18", 18, 3'b111, 1, 0, 0, 0);
    lit("sa_e19", 19, 3'b111, 1, 0, 0, 0);
    lit("sa_e22", 22, 3'b110, 1, 0, 0, 0);
    lit("sa_e30", 30, 3'b000, 1, 0, 0, 0);
    // async reset during WAIT(1)
    por(3'b101, 3);
    lit("ar_e12", 12, 3'b100, 1, 0, 0, 0);
    #3 rst = 1'b1;
    #1;
    chk("ar_rst_out", int'(bus.rst_out), 7);
    chk("ar_busy", int'(bus.busy), 1);
    chk("ar_done", int'(bus.done), 0);
    chk("ar_fault", int'(bus.fault), 0);
    bus.ack = 3'b111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lit("ar2_e6", 6, 3'b110, 1, 0, 0, 0);
    lit("ar2_e10", 10, 3'b100, 1, 0, 0, 0);
    lit("ar2_e14", 14, 3'b000, 1, 0, 0, 0);
    lit("ar2_e16", 16, 3'b000, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sys_rst_seq.md
# sys_rst_seq

Reset sequencer for the system layer. It takes the board-level asynchronous reset and synchronizes its deassertion to `clk`. It then releases up to `N_STAGE` downstream reset domains in a fixed order, one after another. Each stage is gated on that domain's ready acknowledgment, with a hold time, inter-stage gap and ack timeout. Sits between the raw reset input and every `rst` port of the subsystems it owns.

## Interface
- `N_STAGE`, 4: number of sequenced reset outputs (1..16).
- `SYNC_LEN`, 2: reset-deassertion synchronizer depth (>=2).
- `HOLD_CYC`, 16: cycles all outputs stay asserted after synchronized release (>=1).
- `GAP_CYC`, 8: extra cycles between ack of stage k and release of stage k+1 (0 allowed).
- `ACK_TO`, 1024: max ack wait per stage in cycles; 0 disables timeout.

Ports:
- `clk` in 1: single system clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset; assertion asynchronous, deassertion synchronized internally.
- `sw_rst_req` in 1: synchronous single-cycle request to re-run the full sequence.
- `ack` in N_STAGE: per-stage ready (e.g. lock/init done), synchronous to `clk`.
- `rst_out` out N_STAGE: active-high resets to downstream domains, registered.
- `busy` out 1: sequence in progress (HOLD/RELEASE/WAIT/GAP).
- `done` out 1: all stages released and acked.
- `fault` out 1: ack timeout occurred.
- `fault_stage` out max(1,$clog2(N_STAGE)): stage index that timed out.

## Operation
- Reset values (async on `rst`=1): `rst_out`=all 1, `busy`=1, `done`=0, `fault`=0, `fault_stage`=0. Synchronizer flops are preset to asserted. State is SYNC.
- SYNC: wait for synchronizer output to deassert (`SYNC_LEN` edges), then go to HOLD.
- HOLD: hold counter counts `HOLD_CYC` cycles. Then release stage 0 and go to WAIT(0).
- WAIT(k): `rst_out[k]`=0. Sample `ack[k]` each edge.
  - `ack[k]`=1 with k<N_STAGE-1: go to GAP(k), or release k+1 directly if `GAP_CYC`=0.
  - `ack[k]`=1 with k=N_STAGE-1: go to DONE.
  - Timeout counter reaches `ACK_TO` low samples: go to FAULT.
- GAP(k): count `GAP_CYC` cycles, then deassert `rst_out[k+1]` and go to WAIT(k+1).
- DONE: `done`=1, `busy`=0, all `rst_out`=0. Later changes on `ack` are ignored.
- FAULT: `rst_out`=all 1, `fault`=1, `fault_stage`=k, `busy`=0. Remains until `rst` or `sw_rst_req`.
- `sw_rst_req`=1 in any state except SYNC:
  - Next edge: `rst_out`=all 1, `done`=0, `fault`=0, `fault_stage`=0, `busy`=1, counters cleared, state HOLD.
  - Accepted in HOLD too, where it restarts the hold count.
  - Ignored in SYNC.
- Release order is strictly 0..N_STAGE-1. A released stage is never reasserted except by FAULT, `sw_rst_req` or `rst`.
- Only `ack[k]` of the current WAIT stage matters; other ack bits are don't-care.
- Counters are sized to $clog2 of their limit plus 1 and saturate; there is no wrap.

## Timing
- Edge numbering: edge 1 is the first posedge after `rst` falls.
- Synchronized reset deasserts at edge `SYNC_LEN`, and HOLD is entered there. `rst_out[0]` falls at edge `SYNC_LEN+HOLD_CYC`.
- Stage k released at edge r: `ack[k]` is first sampled at r+1. If sampled high at edge e, `rst_out[k+1]` falls at e+GAP_CYC+1.
- Last stage ack sampled at e: `done`=1 and `busy`=0 at e+1.
- Timeout: with `ack[k]` low at edges r+1..r+ACK_TO, FAULT outputs update at edge r+ACK_TO+1.
- `ack` high on the final allowed sample (r+ACK_TO) is success, not fault.
- `sw_rst_req` sampled at s: outputs reasserted at s+1, and `rst_out[0]` falls at s+1+HOLD_CYC.
- Simultaneous `sw_rst_req` and `ack`: `sw_rst_req` wins.
- `rst` assertion mid-sequence: all outputs return to reset values immediately, with no clock required.

## Test plan
Configuration: N_STAGE=3, SYNC_LEN=2, HOLD_CYC=4, GAP_CYC=2, ACK_TO=10.
- Power-on with `rst` high 5 cycles, then low, `ack`=111 → `rst_out[0]` falls at edge 6, `rst_out[1]` at 10, `rst_out[2]` at 14; `done`=1 at edge 16; `busy` falls at 16.
- Same as above, but `ack[1]` tied 0 → `rst_out[1]` falls at 10; at edge 21 `rst_out`=111, `fault`=1, `fault_stage`=1, `done`=0; state holds 50 further cycles.
- `ack[0]` rises exactly at edge 16 (10th sample after release at 6) → no fault; `rst_out[1]` falls at edge 19.
- In DONE, pulse `sw_rst_req` at edge s → `rst_out`=111 and `done`=0 at s+1; `rst_out[0]` falls at s+5; full sequence repeats.
- Same edge carries `sw_rst_req` and the last-stage `ack[2]` → `done` stays 0, `rst_out`=111, HOLD restarts.
- Assert `rst` between edges during WAIT(1) → `rst_out`=111, `busy`=1, `done`=0, `fault`=0 before the next edge; release repeats the first scenario's timing.
